// File: rtl/sr_ff_pkg.sv
// rtl/sr_ff_pkg.sv - shared S=R=1 resolution modes and next-state helper for sr_ff_b
`timescale 1ns/1ps
package sr_ff_pkg;

  localparam int MODE_HOLD   = 0;
  localparam int MODE_SET    = 1;
  localparam int MODE_RESET  = 2;
  localparam int MODE_TOGGLE = 3;

  typedef enum logic [1:0] {
    SR_IDLE  = 2'b00,
    SR_RST   = 2'b01,
    SR_SET   = 2'b10,
    SR_BOTH  = 2'b11
  } sr_req_e;

  function automatic logic sr_next(input logic q, input logic s, input logic r, input int mode);
    logic nq;
    nq = q;
    case (sr_req_e'({s, r}))
      SR_SET:  nq = 1'b1;
      SR_RST:  nq = 1'b0;
      SR_BOTH: begin
        case (mode)
          MODE_SET:    nq = 1'b1;
          MODE_RESET:  nq = 1'b0;
          MODE_TOGGLE: nq = ~q;
          default:     nq = q;
        endcase
      end
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_ff_bit.sv
// rtl/sr_ff_bit.sv - single SR flip-flop bit with registered conflict flag and async clear
`timescale 1ns/1ps
module sr_ff_bit
  import sr_ff_pkg::*;
#(
  parameter int BOTH_MODE = MODE_HOLD
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic s_i,
  input  logic r_i,
  output logic q_o,
  output logic qn_o,
  output logic illegal_o
);

  logic q_q;
  logic q_d;
  logic ill_q;
  logic ill_d;

  always_comb begin
    q_d   = sr_next(q_q, s_i, r_i, BOTH_MODE);
    ill_d = s_i & r_i;
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      q_q   <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ill_q <= ill_d;
    end
  end

  // QN comes from the same flop as Q so the pair can never agree
  assign q_o       = q_q;
  assign qn_o      = ~q_q;
  assign illegal_o = ill_q;

endmodule

// File: rtl/sr_ff_b.sv
// rtl/sr_ff_b.sv - WIDTH independent SR flip-flops with selectable S=R=1 behaviour
`timescale 1ns/1ps
module sr_ff_b
  import sr_ff_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int BOTH_MODE = MODE_HOLD
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic [WIDTH-1:0] ILLEGAL
);

  generate
    if (BOTH_MODE < MODE_HOLD || BOTH_MODE > MODE_TOGGLE) begin : g_bad_mode
      $fatal(1, "sr_ff_b: BOTH_MODE must be 0..3");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $fatal(1, "sr_ff_b: WIDTH must be 1..64");
    end
  endgenerate

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_ff_bit #(
      .BOTH_MODE(BOTH_MODE)
    ) u_bit (
      .clk_i    (CLK),
      .clr_i    (CLR),
      .s_i      (S[i]),
      .r_i      (R[i]),
      .q_o      (Q[i]),
      .qn_o     (QN[i]),
      .illegal_o(ILLEGAL[i])
    );
  end

endmodule

// File: tb/tb_sr_ff_b.sv
// tb/tb_sr_ff_b.sv - directed self-checking bench for sr_ff_b (all four modes, WIDTH=1 and WIDTH=4)
`timescale 1ns/1ps
module tb_sr_ff_b;

    logic       CLK;
    logic       CLR;
    logic       S;
    logic       R;
    logic [3:0] S4;
    logic [3:0] R4;
    logic [3:0] q1;
    logic [3:0] qn1;
    logic [3:0] il1;
    logic [3:0] q4;
    logic [3:0] qn4;
    logic [3:0] il4;
    logic [3:0] exp_q;
    int         n_cmp;
    int         n_err;
    logic       done;

    sr_ff_b #(.WIDTH(1), .BOTH_MODE(0)) dut_m0 (
        .CLK(CLK), .CLR(CLR), .S(S), .R(R), .Q(q1[0]), .QN(qn1[0]), .ILLEGAL(il1[0]));
    sr_ff_b #(.WIDTH(1), .BOTH_MODE(1)) dut_m1 (
        .CLK(CLK), .CLR(CLR), .S(S), .R(R), .Q(q1[1]), .QN(qn1[1]), .ILLEGAL(il1[1]));
    sr_ff_b #(.WIDTH(1), .BOTH_MODE(2)) dut_m2 (
        .CLK(CLK), .CLR(CLR), .S(S), .R(R), .Q(q1[2]), .QN(qn1[2]), .ILLEGAL(il1[2]));
    sr_ff_b #(.WIDTH(1), .BOTH_MODE(3)) dut_m3 (
        .CLK(CLK), .CLR(CLR), .S(S), .R(R), .Q(q1[3]), .QN(qn1[3]), .ILLEGAL(il1[3]));
    sr_ff_b #(.WIDTH(4), .BOTH_MODE(0)) dut_w4 (
        .CLK(CLK), .CLR(CLR), .S(S4), .R(R4), .Q(q4), .QN(qn4), .ILLEGAL(il4));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic report(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        done = 1'b0;
        #20000;
        if (!done) begin
            $error("FAIL timeout: directed sequence did not complete within 20000 ns");
            $finish;
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        CLR = 1'b1; S = 1'b1; R = 1'b0; S4 = 4'h0; R4 = 4'h0;

        #1;
        n_cmp++;
        if (q1 !== 4'h0 || qn1 !== 4'hF || il1 !== 4'h0 ||
            q4 !== 4'h0 || qn4 !== 4'hF || il4 !== 4'h0) begin
            n_err++;
            $error("FAIL reset_state q1=%0h qn1=%0h il1=%0h q4=%0h qn4=%0h il4=%0h",
                   q1, qn1, il1, q4, qn4, il4);
        end
        n_cmp++; if (q1  !== 4'h0) report("rst_q1",  q1,  4'h0);
        n_cmp++; if (qn1 !== 4'hF) report("rst_qn1", qn1, 4'hF);
        n_cmp++; if (il1 !== 4'h0) report("rst_il1", il1, 4'h0);
        n_cmp++; if (q4  !== 4'h0) report("rst_q4",  q4,  4'h0);
        n_cmp++; if (qn4 !== 4'hF) report("rst_qn4", qn4, 4'hF);
        n_cmp++; if (il4 !== 4'h0) report("rst_il4", il4, 4'h0);

        step();
        n_cmp++; if (q1 !== 4'h0) report("clr_blocks_set", q1, 4'h0);

        step();
        CLR = 1'b0;
        n_cmp++; if (q1  !== 4'h0) report("release_edge_no_update", q1, 4'h0);
        n_cmp++; if (qn1 !== 4'hF) report("release_edge_qn", qn1, 4'hF);

        step();
        n_cmp++; if (q1  !== 4'hF) report("set_q",  q1,  4'hF);
        n_cmp++; if (qn1 !== 4'h0) report("set_qn", qn1, 4'h0);
        n_cmp++; if (il1 !== 4'h0) report("set_il", il1, 4'h0);
        for (int i = 0; i < 7; i++) begin
            step();
            n_cmp++; if (q1 !== 4'hF) report("set_held", q1, 4'hF);
        end
        S = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++; if (q1  !== 4'hF) report("hold_after_set_q",  q1,  4'hF);
            n_cmp++; if (qn1 !== 4'h0) report("hold_after_set_qn", qn1, 4'h0);
        end

        R = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++; if (q1  !== 4'h0) report("reset_q",  q1,  4'h0);
            n_cmp++; if (qn1 !== 4'hF) report("reset_qn", qn1, 4'hF);
        end
        R = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++; if (q1 !== 4'h0) report("hold_after_reset_q", q1, 4'h0);
        end

        S = 1'b1;
        step();
        n_cmp++; if (q1 !== 4'hF) report("preset_for_both", q1, 4'hF);

        R = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_q = {i[0], 1'b0, 1'b1, 1'b1};
            n_cmp++; if (q1  !== exp_q)  report("both_q",  q1,  exp_q);
            n_cmp++; if (qn1 !== ~exp_q) report("both_qn", qn1, ~exp_q);
            n_cmp++; if (il1 !== 4'hF)   report("both_il", il1, 4'hF);
        end
        S = 1'b0; R = 1'b0;
        #1;
        n_cmp++; if (il1 !== 4'hF) report("il_no_comb_path", il1, 4'hF);
        step();
        n_cmp++; if (il1 !== 4'h0)    report("il_clears_after_release", il1, 4'h0);
        n_cmp++; if (q1  !== 4'b1011) report("q_after_both_release", q1, 4'b1011);

        #3;
        CLR = 1'b1;
        #1;
        n_cmp++; if (q1  !== 4'h0) report("midcycle_clr_q",  q1,  4'h0);
        n_cmp++; if (qn1 !== 4'hF) report("midcycle_clr_qn", qn1, 4'hF);
        S = 1'b1; R = 1'b0;
        @(posedge CLK);
        #1;
        CLR = 1'b0;
        n_cmp++; if (q1 !== 4'h0) report("clr_release_edge_q", q1, 4'h0);
        step();
        n_cmp++; if (q1 !== 4'hF) report("first_update_after_clr", q1, 4'hF);

        S = 1'b0;
        S4 = 4'b1010; R4 = 4'b0101;
        step();
        n_cmp++; if (q4  !== 4'b1010) report("w4_preload_q",  q4,  4'b1010);
        n_cmp++; if (il4 !== 4'b0000) report("w4_preload_il", il4, 4'b0000);
        S4 = 4'b0101; R4 = 4'b0011;
        step();
        n_cmp++; if (q4  !== 4'b1100) report("w4_mixed_q",  q4,  4'b1100);
        n_cmp++; if (qn4 !== 4'b0011) report("w4_mixed_qn", qn4, 4'b0011);
        n_cmp++; if (il4 !== 4'b0001) report("w4_mixed_il", il4, 4'b0001);
        S4 = 4'h0; R4 = 4'h0;
        step();
        n_cmp++; if (q4  !== 4'b1100) report("w4_hold_q",  q4,  4'b1100);
        n_cmp++; if (il4 !== 4'b0000) report("w4_hold_il", il4, 4'b0000);

        #2;
        CLR = 1'b1;
        #1;
        n_cmp++; if (q4  !== 4'h0) report("w4_clr_q",  q4,  4'h0);
        n_cmp++; if (qn4 !== 4'hF) report("w4_clr_qn", qn4, 4'hF);
        n_cmp++; if (q1  !== 4'h0) report("w4_clr_q1", q1,  4'h0);

        done = 1'b1;
        if (n_err != 0) begin
            $error("FAIL summary: %0d of %0d comparisons mismatched", n_err, n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
